// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, helper function and types for the register file
package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_NREGS = 32;

  function automatic int regnum_width(input int n);
    return $clog2(n);
  endfunction

  typedef logic [REGFILE_NREGS-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits: writeback clears, issue sets (set wins)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = REGFILE_NREGS,
  parameter int ZERO_REG = 1,
  localparam int RW      = regnum_width(NREGS)
) (
  input  logic             clk,
  input  logic             resetn_i,
  input  logic             wr0_enable_i,
  input  logic [RW-1:0]    wr0_regnum_i,
  input  logic             wr1_enable_i,
  input  logic [RW-1:0]    wr1_regnum_i,
  input  logic             issue_enable_i,
  input  logic [RW-1:0]    issue_regnum_i,
  output logic [NREGS-1:0] busy_o,
  output logic             any_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // A new producer issued while the old one retires keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr0_enable_i) busy_d[wr0_regnum_i] = 1'b0;
    if (wr1_enable_i) busy_d[wr1_regnum_i] = 1'b0;
    if (issue_enable_i) busy_d[issue_regnum_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule

// File: rtl/mips_regfile_2w.sv
// rtl/mips_regfile_2w.sv - two-read/two-write register file with busy scoreboard
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module mips_regfile_2w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int NREGS    = REGFILE_NREGS,
  parameter int ZERO_REG = 1,
  localparam int RW      = regnum_width(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    rd1_regnum,
  input  logic [RW-1:0]    rd2_regnum,
  output logic [WIDTH-1:0] rd1_data,
  output logic [WIDTH-1:0] rd2_data,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic             wr0_enable,
  input  logic [RW-1:0]    wr0_regnum,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_enable,
  input  logic [RW-1:0]    wr1_regnum,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             issue_enable,
  input  logic [RW-1:0]    issue_regnum,
  output logic             any_busy
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy;

  // wr1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr0_enable) regs_d[wr0_regnum] = wr0_data;
    if (wr1_enable) regs_d[wr1_regnum] = wr1_data;
    if (ZERO_REG != 0) regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .resetn_i       (reset),
    .wr0_enable_i   (wr0_enable),
    .wr0_regnum_i   (wr0_regnum),
    .wr1_enable_i   (wr1_enable),
    .wr1_regnum_i   (wr1_regnum),
    .issue_enable_i (issue_enable),
    .issue_regnum_i (issue_regnum),
    .busy_o         (busy),
    .any_busy_o     (any_busy)
  );

  // Returns {busy, data} as seen by a read port addressing rn.
  function automatic logic [WIDTH:0] read_port(input logic [RW-1:0] rn);
    logic [WIDTH:0] r;
    r = {busy[rn], regs_q[rn]};
`ifdef REGFILE_BYPASS_EN
    if (!(ZERO_REG != 0 && rn == '0)) begin
      if (wr1_enable && wr1_regnum == rn) begin
        r = {issue_enable && issue_regnum == rn, wr1_data};
      end else if (wr0_enable && wr0_regnum == rn) begin
        r = {issue_enable && issue_regnum == rn, wr0_data};
      end
    end
`endif
    return r;
  endfunction

  always_comb begin
    {rd1_busy, rd1_data} = read_port(rd1_regnum);
    {rd2_busy, rd2_data} = read_port(rd2_regnum);
  end

endmodule

// File: tb/tb_mips_regfile_2w.sv
// tb/tb_mips_regfile_2w.sv - directed checks on the default build, model-checked random soak on a small build
module tb_mips_regfile_2w;

  localparam int AW  = 32;
  localparam int AN  = 32;
  localparam int ARW = 5;
  localparam int BW  = 16;
  localparam int BN  = 8;
  localparam int BRW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic           a_reset;
  logic [ARW-1:0] a_rd1_rn, a_rd2_rn, a_wr0_rn, a_wr1_rn, a_issue_rn;
  logic [AW-1:0]  a_rd1_data, a_rd2_data, a_wr0_data, a_wr1_data;
  logic           a_rd1_busy, a_rd2_busy, a_wr0_en, a_wr1_en, a_issue_en, a_any_busy;

  mips_regfile_2w #(.WIDTH(AW), .NREGS(AN), .ZERO_REG(1)) u_dut_a (
    .clk          (clk),
    .reset        (a_reset),
    .rd1_regnum   (a_rd1_rn),
    .rd2_regnum   (a_rd2_rn),
    .rd1_data     (a_rd1_data),
    .rd2_data     (a_rd2_data),
    .rd1_busy     (a_rd1_busy),
    .rd2_busy     (a_rd2_busy),
    .wr0_enable   (a_wr0_en),
    .wr0_regnum   (a_wr0_rn),
    .wr0_data     (a_wr0_data),
    .wr1_enable   (a_wr1_en),
    .wr1_regnum   (a_wr1_rn),
    .wr1_data     (a_wr1_data),
    .issue_enable (a_issue_en),
    .issue_regnum (a_issue_rn),
    .any_busy     (a_any_busy)
  );

  // ---------------- instance B: WIDTH=16, NREGS=8, ZERO_REG=0 ----------------
  logic           b_reset;
  logic [BRW-1:0] b_rd1_rn, b_rd2_rn, b_wr0_rn, b_wr1_rn, b_issue_rn;
  logic [BW-1:0]  b_rd1_data, b_rd2_data, b_wr0_data, b_wr1_data;
  logic           b_rd1_busy, b_rd2_busy, b_wr0_en, b_wr1_en, b_issue_en, b_any_busy;

  mips_regfile_2w #(.WIDTH(BW), .NREGS(BN), .ZERO_REG(0)) u_dut_b (
    .clk          (clk),
    .reset        (b_reset),
    .rd1_regnum   (b_rd1_rn),
    .rd2_regnum   (b_rd2_rn),
    .rd1_data     (b_rd1_data),
    .rd2_data     (b_rd2_data),
    .rd1_busy     (b_rd1_busy),
    .rd2_busy     (b_rd2_busy),
    .wr0_enable   (b_wr0_en),
    .wr0_regnum   (b_wr0_rn),
    .wr0_data     (b_wr0_data),
    .wr1_enable   (b_wr1_en),
    .wr1_regnum   (b_wr1_rn),
    .wr1_data     (b_wr1_data),
    .issue_enable (b_issue_en),
    .issue_regnum (b_issue_rn),
    .any_busy     (b_any_busy)
  );

  // Reference model for instance B: plain arrays of register contents and busy flags.
  logic [BW-1:0] m_mem  [BN];
  bit            m_busy [BN];
  bit            soak_on = 1'b0;

  task automatic m_step();
    if (!b_reset) begin
      for (int i = 0; i < BN; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (b_wr0_en) begin m_mem[b_wr0_rn] = b_wr0_data; m_busy[b_wr0_rn] = 1'b0; end
      if (b_wr1_en) begin m_mem[b_wr1_rn] = b_wr1_data; m_busy[b_wr1_rn] = 1'b0; end
      if (b_issue_en) m_busy[b_issue_rn] = 1'b1;
    end
  endtask

  function automatic logic [BW-1:0] exp_data(input logic [BRW-1:0] rn);
`ifdef REGFILE_BYPASS_EN
    if (b_wr1_en && b_wr1_rn == rn) return b_wr1_data;
    if (b_wr0_en && b_wr0_rn == rn) return b_wr0_data;
`endif
    return m_mem[rn];
  endfunction

  function automatic logic exp_busy(input logic [BRW-1:0] rn);
`ifdef REGFILE_BYPASS_EN
    if ((b_wr1_en && b_wr1_rn == rn) || (b_wr0_en && b_wr0_rn == rn))
      return b_issue_en && b_issue_rn == rn;
`endif
    return m_busy[rn];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < BN; i++) r = r | m_busy[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (soak_on) begin
      check("b_rd1_data", 64'(b_rd1_data), 64'(exp_data(b_rd1_rn)));
      check("b_rd2_data", 64'(b_rd2_data), 64'(exp_data(b_rd2_rn)));
      check("b_rd1_busy", 64'(b_rd1_busy), 64'(exp_busy(b_rd1_rn)));
      check("b_rd2_busy", 64'(b_rd2_busy), 64'(exp_busy(b_rd2_rn)));
      check("b_any_busy", 64'(b_any_busy), 64'(exp_any()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_reset = 1'b1; a_wr0_en = 1'b0; a_wr1_en = 1'b0; a_issue_en = 1'b0;
  endtask

  // Instance B step: model follows the edge, then new inputs are applied.
  task automatic b_tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic b_clear();
    b_reset = 1'b1; b_wr0_en = 1'b0; b_wr1_en = 1'b0; b_issue_en = 1'b0;
  endtask

  initial begin
    a_reset = 1'b0; a_rd1_rn = '0; a_rd2_rn = '0; a_wr0_en = 1'b0; a_wr0_rn = '0; a_wr0_data = '0;
    a_wr1_en = 1'b0; a_wr1_rn = '0; a_wr1_data = '0; a_issue_en = 1'b0; a_issue_rn = '0;
    b_reset = 1'b0; b_rd1_rn = '0; b_rd2_rn = '0; b_wr0_en = 1'b0; b_wr0_rn = '0; b_wr0_data = '0;
    b_wr1_en = 1'b0; b_wr1_rn = '0; b_wr1_data = '0; b_issue_en = 1'b0; b_issue_rn = '0;

    tick(); tick();
    a_idle();
    check("a_reset_any_busy", 64'(a_any_busy), 64'h0);
    a_rd1_rn = 5'd17; a_rd2_rn = 5'd31; #1;
    check("a_reset_rd1_data", 64'(a_rd1_data), 64'h0);
    check("a_reset_rd2_busy", 64'(a_rd2_busy), 64'h0);

    // Write r5, mark r6 busy, then reset while also writing r9.
    a_wr0_en = 1'b1; a_wr0_rn = 5'd5; a_wr0_data = 32'hdeadbeef;
    a_issue_en = 1'b1; a_issue_rn = 5'd6;
    tick(); a_idle();
    a_rd1_rn = 5'd5; a_rd2_rn = 5'd6; #1;
    check("a_pre_reset_r5", 64'(a_rd1_data), 64'hdeadbeef);
    check("a_pre_reset_any", 64'(a_any_busy), 64'h1);
    a_reset = 1'b0; a_wr0_en = 1'b1; a_wr0_rn = 5'd9; a_wr0_data = 32'h12345678;
    a_issue_en = 1'b1; a_issue_rn = 5'd10;
    tick(); a_idle(); #1;
    check("a_post_reset_r5", 64'(a_rd1_data), 64'h0);
    check("a_post_reset_r6_busy", 64'(a_rd2_busy), 64'h0);
    check("a_post_reset_any", 64'(a_any_busy), 64'h0);
    a_rd1_rn = 5'd9; #1;
    check("a_reset_overrides_write", 64'(a_rd1_data), 64'h0);

    // Basic writes on each port.
    a_wr0_en = 1'b1; a_wr0_rn = 5'd1; a_wr0_data = 32'hffffffff;
    tick(); a_idle();
    a_wr1_en = 1'b1; a_wr1_rn = 5'd2; a_wr1_data = 32'h31240498;
    tick(); a_idle();
    a_rd1_rn = 5'd1; a_rd2_rn = 5'd2; #1;
    check("a_wr0_r1", 64'(a_rd1_data), 64'hffffffff);
    check("a_wr1_r2", 64'(a_rd2_data), 64'h31240498);

    // Collision and zero register.
    a_wr0_en = 1'b1; a_wr0_rn = 5'd3; a_wr0_data = 32'h08888888;
    a_wr1_en = 1'b1; a_wr1_rn = 5'd3; a_wr1_data = 32'h07878787;
    tick(); a_idle();
    a_rd1_rn = 5'd3; a_rd2_rn = 5'd3; #1;
    check("a_collision_rd1", 64'(a_rd1_data), 64'h07878787);
    check("a_collision_rd2", 64'(a_rd2_data), 64'h07878787);
    a_wr0_en = 1'b1; a_wr0_rn = 5'd0; a_wr0_data = 32'h87654321;
    tick(); a_idle();
    a_rd1_rn = 5'd0; #1;
    check("a_zero_reg_data", 64'(a_rd1_data), 64'h0);

    // Scoreboard.
    a_issue_en = 1'b1; a_issue_rn = 5'd4;
    tick(); a_idle();
    a_rd1_rn = 5'd4; #1;
    check("a_issue_busy", 64'(a_rd1_busy), 64'h1);
    check("a_issue_any", 64'(a_any_busy), 64'h1);
    a_issue_en = 1'b1; a_issue_rn = 5'd4;
    tick(); a_idle(); #1;
    check("a_reissue_busy", 64'(a_rd1_busy), 64'h1);
    a_wr0_en = 1'b1; a_wr0_rn = 5'd4; a_wr0_data = 32'h13145120;
    tick(); a_idle(); #1;
    check("a_write_clears_busy", 64'(a_rd1_busy), 64'h0);
    check("a_write_clears_any", 64'(a_any_busy), 64'h0);
    check("a_write_data_r4", 64'(a_rd1_data), 64'h13145120);
    a_issue_en = 1'b1; a_issue_rn = 5'd4;
    a_wr1_en = 1'b1; a_wr1_rn = 5'd4; a_wr1_data = 32'h55aa55aa;
    tick(); a_idle(); #1;
    check("a_set_wins_busy", 64'(a_rd1_busy), 64'h1);
    check("a_set_wins_data", 64'(a_rd1_data), 64'h55aa55aa);
    a_wr0_en = 1'b1; a_wr0_rn = 5'd4; a_wr0_data = 32'h0;
    tick(); a_idle();
    a_issue_en = 1'b1; a_issue_rn = 5'd0;
    tick(); a_idle();
    a_rd1_rn = 5'd0; #1;
    check("a_zero_never_busy", 64'(a_rd1_busy), 64'h0);
    check("a_zero_issue_any", 64'(a_any_busy), 64'h0);

    // Same-cycle write-to-read behaviour.
    a_rd2_rn = 5'd7;
    a_wr0_en = 1'b1; a_wr0_rn = 5'd7; a_wr0_data = 32'h11111111;
    a_wr1_en = 1'b1; a_wr1_rn = 5'd7; a_wr1_data = 32'hcafef00d; #1;
`ifdef REGFILE_BYPASS_EN
    check("a_bypass_same_cycle", 64'(a_rd2_data), 64'hcafef00d);
`else
    check("a_no_bypass_same_cycle", 64'(a_rd2_data), 64'h0);
`endif
    check("a_bypass_busy_r7", 64'(a_rd2_busy), 64'h0);
    tick(); a_idle(); #1;
    check("a_r7_next_cycle", 64'(a_rd2_data), 64'hcafef00d);

    a_issue_en = 1'b1; a_issue_rn = 5'd8;
    tick(); a_idle();
    a_rd1_rn = 5'd8; a_wr0_en = 1'b1; a_wr0_rn = 5'd8; a_wr0_data = 32'h0000abcd; #1;
`ifdef REGFILE_BYPASS_EN
    check("a_bypass_busy_cleared", 64'(a_rd1_busy), 64'h0);
    check("a_bypass_data_r8", 64'(a_rd1_data), 64'h0000abcd);
`else
    check("a_busy_registered", 64'(a_rd1_busy), 64'h1);
    check("a_old_data_r8", 64'(a_rd1_data), 64'h0);
`endif
    a_issue_en = 1'b1; a_issue_rn = 5'd8; #1;
    check("a_issue_with_write_busy", 64'(a_rd1_busy), 64'h1);
    tick(); a_idle(); #1;
    check("a_r8_still_busy", 64'(a_rd1_busy), 64'h1);
    check("a_r8_data", 64'(a_rd1_data), 64'h0000abcd);

    a_rd1_rn = 5'd0; a_wr1_en = 1'b1; a_wr1_rn = 5'd0; a_wr1_data = 32'hffffffff; #1;
    check("a_zero_not_bypassed", 64'(a_rd1_data), 64'h0);
    tick(); a_idle(); #1;
    check("a_zero_after_write", 64'(a_rd1_data), 64'h0);

    // ---------------- instance B: scripted pins, then random soak ----------------
    b_reset = 1'b0;
    b_tick();
    soak_on = 1'b1;
    b_clear();
    b_wr0_en = 1'b1; b_wr0_rn = 3'd0; b_wr0_data = 16'h1234;
    b_wr1_en = 1'b1; b_wr1_rn = 3'd0; b_wr1_data = 16'hbeef;
    b_issue_en = 1'b1; b_issue_rn = 3'd0;
    b_tick(); b_clear();
    b_rd1_rn = 3'd0; #1;
    check("m_pin_r0_data", 64'(m_mem[0]), 64'hbeef);
    check("b_pin_r0_data", 64'(b_rd1_data), 64'hbeef);
    check("b_pin_r0_busy", 64'(b_rd1_busy), 64'h1);
    b_wr0_en = 1'b1; b_wr0_rn = 3'd0; b_wr0_data = 16'h0042;
    b_tick(); b_clear(); #1;
    check("m_pin_r0_cleared", 64'(m_busy[0]), 64'h0);
    check("b_pin_any_busy", 64'(b_any_busy), 64'h0);

    for (int cyc = 0; cyc < 1000; cyc++) begin
      b_reset    = ($urandom_range(0, 49) != 0);
      b_wr0_en   = $urandom_range(0, 1) == 1;
      b_wr0_rn   = BRW'($urandom_range(0, BN - 1));
      b_wr0_data = BW'($urandom);
      b_wr1_en   = $urandom_range(0, 1) == 1;
      b_wr1_rn   = BRW'($urandom_range(0, BN - 1));
      b_wr1_data = BW'($urandom);
      b_issue_en = $urandom_range(0, 9) < 4;
      b_issue_rn = BRW'($urandom_range(0, BN - 1));
      b_rd1_rn   = BRW'($urandom_range(0, BN - 1));
      b_rd2_rn   = ($urandom_range(0, 3) == 0) ? b_rd1_rn : BRW'($urandom_range(0, BN - 1));
      b_tick();
    end
    soak_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
